piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits (legal range 2..32).
REQ-002 Parameter PARITY_EN, default 1: when 1, an even-parity bit follows the data bits.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 reset  input  1  The reset is asynchronous and active-low (reset = 0 resets the block).
REQ-005 data_in  input  WIDTH  Parallel word to transmit; sampled only on the accept edge.
REQ-006 load_valid  input  1  Requester has a word on data_in.
REQ-007 load_ready  output  1  Block can accept a word; driven combinationally from state (high only in IDLE).
REQ-008 sout  output  1  Serial output, registered; idle level 1.
REQ-009 sout_bar  output  1  Always the complement of sout.
REQ-010 frame  output  1  Registered; high while data or parity bits are on sout.
REQ-011 done  output  1  Registered single-cycle pulse after the last bit of a word.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PARITY, DONE.
REQ-013 An accept SHALL occur on a rising edge where load_valid=1 and load_ready=1; load_valid at any other time SHALL be ignored.
REQ-014 On the accept edge: shift register <= data_in, bit counter <= 0, state -> SHIFT, sout <= data_in[WIDTH-1], frame <= 1.
REQ-015 In SHIFT, each edge SHALL present the next lower bit (MSB first); sout holds each bit for exactly one cycle.
REQ-016 The edge after bit 0 has been presented SHALL go to PARITY (if PARITY_EN=1) with sout = XOR of all data bits, else directly to DONE.
REQ-017 Entering DONE: sout <= 1, frame <= 0, done <= 1 for exactly one cycle; the next edge -> IDLE.
REQ-018 In IDLE: sout = 1, frame = 0, done = 0.
REQ-019 Changes on data_in after the accept edge SHALL NOT affect the word in flight.
REQ-020 load_ready SHALL be 0 in SHIFT, PARITY and DONE; no accept is possible during DONE.
REQ-021 The minimum accept-to-accept spacing SHALL be WIDTH + PARITY_EN + 2 cycles.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within a word.

Reset
REQ-023 While reset = 0: state = IDLE, sout = 1, sout_bar = 0, frame = 0, done = 0, load_ready = 1, shift register and counter = 0.
REQ-024 An assertion of reset mid-word SHALL abort the word immediately (asynchronously); no done pulse is issued.
REQ-025 The first accept possible after reset deassertion SHALL be on the first rising edge after deassertion.

Structure
REQ-026 Package serializer_pkg SHALL hold the state enum (ser_state_t) and the default WIDTH constant.
REQ-027 One sub-module, bit_counter (clear, enable, count, terminal flag at WIDTH-1), SHALL be instantiated.
REQ-028 The shift register and FSM SHALL reside in piso_serializer.

Verification (WIDTH=8, PARITY_EN=1)
REQ-029 Accept 8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 on edges 0..7, parity 0 on edge 8, done pulse on edge 9, load_ready = 1 on edge 10.
REQ-030 Accept 8'h07 -> parity bit 1; frame high for exactly 9 cycles.
REQ-031 Hold load_valid = 1 continuously with 8'hFF then 8'h00 -> accepts are exactly 11 cycles apart; sout_bar == ~sout in every cycle.
REQ-032 Drive reset low on the 4th bit of 8'h3C -> sout = 1, frame = 0, and load_ready = 1 immediately; no done pulse.
REQ-033 Change data_in to 8'h00 one cycle after accepting 8'hC3 -> serial output still carries 8'hC3.
REQ-034 Pulse load_valid during DONE -> pulse ignored; no second word transmitted.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and constants for the PISO serializer.
package serializer_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity,
    StDone
  } ser_state_t;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter: clears on a new word, counts up while enabled and
// saturates at Width-1 so it never wraps inside a word.
module bit_counter #(
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Width)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            en_i,
  output logic [CntW-1:0] count_o,
  output logic            term_o
);

  logic [CntW-1:0] count_d, count_q;

  assign term_o  = (count_q == CntW'(Width - 1));
  assign count_o = count_q;

  // Next count: clear wins, otherwise advance until the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !term_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, with optional even parity
// bit and a one-cycle done pulse after each word.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_bar,
  output logic             frame,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  ser_state_t       state_d, state_q;
  logic [WIDTH-1:0] sreg_d, sreg_q;
  logic             sout_d, sout_q;
  logic             frame_d, frame_q;
  logic             done_d, done_q;

  logic             accept;
  logic [CntW-1:0]  cnt_count;
  logic             cnt_term;

  assign load_ready = (state_q == StIdle);
  assign accept     = load_valid & load_ready;

  assign sout     = sout_q;
  assign sout_bar = ~sout_q;
  assign frame    = frame_q;
  assign done     = done_q;

  bit_counter #(
    .Width(WIDTH)
  ) u_bit_counter (
    .clk_i  (clk),
    .rst_ni (reset),
    .clear_i(accept),
    .en_i   (state_q == StShift),
    .count_o(cnt_count),
    .term_o (cnt_term)
  );

  // Only the terminal flag steers the FSM; the raw count is informational.
  logic unused_cnt;
  assign unused_cnt = ^cnt_count;

  // Next-state and registered-output logic. The shift register rotates rather
  // than shifts so its XOR stays equal to the parity of the accepted word.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    sout_d  = sout_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sout_d  = 1'b1;
        frame_d = 1'b0;
        if (accept) begin
          sreg_d  = data_in;
          sout_d  = data_in[WIDTH-1];
          frame_d = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_term) begin
          if (PARITY_EN) begin
            sout_d  = ^sreg_q;
            state_d = StParity;
          end else begin
            sout_d  = 1'b1;
            frame_d = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          sreg_d = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
          sout_d = sreg_q[WIDTH-2];
        end
      end
      StParity: begin
        sout_d  = 1'b1;
        frame_d = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        sout_d  = 1'b1;
        frame_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        sout_d  = 1'b1;
        frame_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      sout_q  <= 1'b1;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      sout_q  <= sout_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

endmodule
